fifo_rd_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 37 +++
 rtl/fifo_rd_arbiter_rr_prio_sel.sv | 22 ++
 rtl/fifo_rd_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_rd_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and the circular-priority helper for the FIFO read-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Upper bound on consumers the helper can search; callers pass their real count.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_IDX_W = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req[n-1:0], searching circularly from last+1.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [MAX_IDX_W-1:0] last,
                                         input int unsigned          n);
        rr_pick_t    r;
        int unsigned pos;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(last) + 32'd1 + k;
            if (pos >= n) pos = pos - n;
            if (pos >= n) pos = pos - n;
            if ((k < n) && !r.found && req[pos[MAX_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = pos[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_prio_sel.sv
// Combinational round-robin selector: lowest-priority slot is the last winner.
module rr_prio_sel
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               found_o,
    output logic [IW-1:0]      idx_o
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(last_i), NUM_REQ);
        found_o = pick.found;
        idx_o   = IW'(pick.idx);
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler: round-robin, burst-limited sharing of the async FIFO read port.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               rclk,
    input  logic               rrst,
    input  logic               rempty,
    input  logic [DSIZE-1:0]   rdata,
    output logic               rinc,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [DSIZE-1:0]   out_data,
    output logic [NUM_REQ-1:0] out_valid,
    output logic               busy
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IW-1:0]      last_q;
    logic [BW-1:0]      bcnt_q;
    logic [BW-1:0]      bcnt_d;
    logic [DSIZE-1:0]   out_data_q;
    logic [NUM_REQ-1:0] out_valid_q;

    logic               sel_found;
    logic [IW-1:0]      sel_idx;
    logic [NUM_REQ-1:0] sel_onehot;
    logic               pop;

    rr_prio_sel #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_sel (
        .req_i   (req),
        .last_i  (last_q),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    assign sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;

    // Only the granted consumer's request counts; gnt_q is zero outside GRANT.
    assign pop    = (state_q == GRANT) && (|(req & gnt_q)) && !rempty;
    assign bcnt_d = bcnt_q + 1'b1;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_q      <= IW'(NUM_REQ - 1);
            bcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= '0;
                    if (arb_en && sel_found && !rempty) begin
                        gnt_q   <= sel_onehot;
                        last_q  <= sel_idx;
                        bcnt_q  <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (pop) begin
                        out_data_q  <= rdata;
                        out_valid_q <= gnt_q;
                        if (bcnt_d == BW'(MAX_BURST)) begin
                            gnt_q   <= '0;
                            bcnt_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            bcnt_q <= bcnt_d;
                        end
                    end else begin
                        // No pop means the consumer dropped its request or the FIFO ran dry.
                        out_valid_q <= '0;
                        gnt_q       <= '0;
                        bcnt_q      <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    bcnt_q      <= '0;
                    out_valid_q <= '0;
                end
            endcase
        end
    end

    assign rinc      = pop;
    assign gnt       = gnt_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a small behavioural FIFO on the read side.
module tb_fifo_rd_arbiter;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       arb_en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic       busy;

    logic [7:0] mem [0:255];
    logic [7:0] rptr = '0;
    logic [7:0] wptr = '0;

    int    n_run  = 0;
    int    n_fail = 0;
    string phase  = "init";

    fifo_rd_arbiter #(
        .NUM_REQ   (4),
        .DSIZE     (8),
        .MAX_BURST (4)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .arb_en    (arb_en),
        .req       (req),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 rclk = ~rclk;

    assign rdata  = mem[rptr];
    assign rempty = (rptr == wptr);

    always @(posedge rclk) begin
        if (rrst)      rptr <= '0;
        else if (rinc) rptr <= rptr + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wptr] = d;
        wptr      = wptr + 8'd1;
    endtask

    // Check one cycle's outputs, then advance to 1 time unit after the next edge.
    task automatic cyc(input logic [3:0] ge, input logic re, input logic [3:0] ve,
                       input logic [7:0] de);
        #1;
        check("gnt", 32'(gnt), 32'(ge));
        check("rinc", 32'(rinc), 32'(re));
        check("out_valid", 32'(out_valid), 32'(ve));
        check("busy", 32'(busy), 32'(ge != 4'b0000));
        if (ve != 4'b0000) check("out_data", 32'(out_data), 32'(de));
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        req  = 4'b0000;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        wptr = '0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
    endtask

    initial begin
        rrst   = 1'b1;
        req    = 4'b0000;
        arb_en = 1'b1;

        phase = "single";
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        req = 4'b0001;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0001, 8'h11);
        cyc(4'b0001, 1'b1, 4'b0001, 8'h22);
        cyc(4'b0001, 1'b0, 4'b0001, 8'h33);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);

        phase = "burst";
        do_reset();
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        req = 4'b0001;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hA0);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hA1);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hA2);
        cyc(4'b0000, 1'b0, 4'b0001, 8'hA3);
        cyc(4'b0001, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hA4);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hA5);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hA6);
        cyc(4'b0000, 1'b0, 4'b0001, 8'hA7);
        cyc(4'b0001, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hA8);
        cyc(4'b0001, 1'b0, 4'b0001, 8'hA9);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);

        phase = "round_robin";
        do_reset();
        for (int i = 0; i < 12; i++) push(8'hB0 + 8'(i));
        req = 4'b1011;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hB0);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hB1);
        cyc(4'b0001, 1'b1, 4'b0001, 8'hB2);
        cyc(4'b0000, 1'b0, 4'b0001, 8'hB3);
        cyc(4'b0010, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0010, 1'b1, 4'b0010, 8'hB4);
        cyc(4'b0010, 1'b1, 4'b0010, 8'hB5);
        cyc(4'b0010, 1'b1, 4'b0010, 8'hB6);
        cyc(4'b0000, 1'b0, 4'b0010, 8'hB7);
        cyc(4'b1000, 1'b1, 4'b0000, 8'h00);
        cyc(4'b1000, 1'b1, 4'b1000, 8'hB8);
        cyc(4'b1000, 1'b1, 4'b1000, 8'hB9);
        cyc(4'b1000, 1'b1, 4'b1000, 8'hBA);
        cyc(4'b0000, 1'b0, 4'b1000, 8'hBB);
        push(8'hBC);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b0, 4'b0001, 8'hBC);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);

        phase = "empty_mid";
        do_reset();
        push(8'hC0); push(8'hC1);
        req = 4'b0010;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0010, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0010, 1'b1, 4'b0010, 8'hC0);
        cyc(4'b0010, 1'b0, 4'b0010, 8'hC1);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);

        phase = "req_drop";
        do_reset();
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
        req = 4'b0100;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0100, 1'b1, 4'b0000, 8'h00);
        req = 4'b0000;
        cyc(4'b0100, 1'b0, 4'b0100, 8'hD0);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);

        phase = "arb_en";
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
        req = 4'b0100;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        arb_en = 1'b0;
        cyc(4'b0100, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0100, 1'b1, 4'b0100, 8'hD1);
        cyc(4'b0100, 1'b1, 4'b0100, 8'hD2);
        cyc(4'b0100, 1'b1, 4'b0100, 8'hD3);
        cyc(4'b0000, 1'b0, 4'b0100, 8'hE0);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        arb_en = 1'b1;
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0100, 1'b1, 4'b0000, 8'h00);

        phase = "reset_mid";
        rrst = 1'b1;
        req  = 4'b1111;
        cyc(4'b0100, 1'b1, 4'b0100, 8'hE1);
        rrst = 1'b0;
        wptr = '0;
        push(8'hF0);
        #1;
        check("post_rst_out_data", 32'(out_data), 32'd0);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b1, 4'b0000, 8'h00);
        cyc(4'b0001, 1'b0, 4'b0001, 8'hF0);
        cyc(4'b0000, 1'b0, 4'b0000, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
